fd_skid_reg: RTL and testbench

Elastic fetch/decode pipeline register: replaces a plain stall/clear register with a two-entry valid/ready buffer, so the instruction stream tolerates decode backpressure without a combinational ready path back into fetch. Sits between the fetch stage (instruction memory, PC logic) and the decode stage. Carries instruction, PC and PC+4. Provides pipeline flush with NOP insertion and a saturating bubble counter for performance monitoring.

---
 rtl/fd_skid_reg.sv | 131 +++++++++++++
 tb/tb_fd_skid_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fd_skid_reg.sv
// Elastic fetch/decode pipeline register: two-entry valid/ready buffer with a
// registered IN_READY, flush with NOP insertion and a saturating bubble counter.
module fd_skid_reg #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013,
    parameter int              CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [XLEN-1:0]  INSTR_F,
    input  logic [XLEN-1:0]  PC_F,
    input  logic [XLEN-1:0]  PCPLUS4_F,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  INSTR_D,
    output logic [XLEN-1:0]  PC_D,
    output logic [XLEN-1:0]  PCPLUS4_D,
    input  logic             CNT_CLR,
    output logic [CNT_W-1:0] BUBBLE_CNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
    } entry_t;

    localparam entry_t          NOP_ENTRY = {NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           in_entry;
    logic             in_fire, out_fire;
    logic [CNT_W-1:0] cnt_q;

    // Handshake flags come straight off the state register, so OUT_READY
    // never reaches IN_READY combinationally.
    assign IN_READY  = (state_q != TWO);
    assign OUT_VALID = (state_q != EMPTY);
    assign in_fire   = IN_VALID & IN_READY;
    assign out_fire  = OUT_VALID & OUT_READY;
    assign in_entry  = '{instr: INSTR_F, pc: PC_F, pcplus4: PCPLUS4_F};

    assign INSTR_D    = main_q.instr;
    assign PC_D       = main_q.pc;
    assign PCPLUS4_D  = main_q.pcplus4;
    assign BUBBLE_CNT = cnt_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value unassigned and infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            state_d = EMPTY;
            main_d  = NOP_ENTRY;
            skid_d  = NOP_ENTRY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_entry;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
                    end else if (in_fire) begin
                        state_d = TWO;
                        skid_d  = in_entry;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = NOP_ENTRY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = NOP_ENTRY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_ENTRY;
                    skid_d  = NOP_ENTRY;
                end
            endcase
        end
    end

    // NOTE: the data entries are reset too, because the outputs are driven
    // directly from the main entry and must read as a NOP while empty.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= EMPTY;
            main_q  <= NOP_ENTRY;
            skid_q  <= NOP_ENTRY;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Bubble counter ignores FLUSH; a clear wins over the increment.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else if (CNT_CLR) begin
            cnt_q <= '0;
        end else if ((state_q == EMPTY) && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_fd_skid_reg.sv
// Self-checking bench for fd_skid_reg: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_fd_skid_reg;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int          CW  = 4;
    localparam int          CMAX = 15;

    logic        CLK = 1'b0;
    logic        RST;
    logic        FLUSH, IN_VALID, IN_READY, OUT_VALID, OUT_READY, CNT_CLR;
    logic [31:0] INSTR_F, PC_F, PCPLUS4_F, INSTR_D, PC_D, PCPLUS4_D;
    logic [CW-1:0] BUBBLE_CNT;

    int n_tests = 0;
    int n_fail  = 0;

    fd_skid_reg #(.XLEN(32), .NOP_INSTR(NOP), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .INSTR_F(INSTR_F), .PC_F(PC_F), .PCPLUS4_F(PCPLUS4_F),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .INSTR_D(INSTR_D), .PC_D(PC_D), .PCPLUS4_D(PCPLUS4_D),
        .CNT_CLR(CNT_CLR), .BUBBLE_CNT(BUBBLE_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {pc[19:0], 12'h093};
    endfunction

    // Reference model: a FIFO of at most two instructions.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcp4;
    } ent_t;

    ent_t q[$];
    int   m_cnt;
    bit   m_in_fire, m_out_fire;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q.delete();
            m_cnt = 0;
        end else begin
            m_out_fire = (q.size() > 0) && OUT_READY;
            m_in_fire  = IN_VALID && (q.size() < 2);
            if (CNT_CLR) m_cnt = 0;
            else if (q.size() == 0 && m_cnt < CMAX) m_cnt++;
            if (FLUSH) begin
                q.delete();
            end else begin
                if (m_out_fire) void'(q.pop_front());
                if (m_in_fire) q.push_back('{INSTR_F, PC_F, PCPLUS4_F});
            end
        end
    end

    always @(negedge CLK) begin
        check("m_out_valid", {31'b0, OUT_VALID}, {31'b0, q.size() > 0});
        check("m_in_ready",  {31'b0, IN_READY},  {31'b0, q.size() < 2});
        check("m_instr_d",   INSTR_D,   (q.size() > 0) ? q[0].instr : NOP);
        check("m_pc_d",      PC_D,      (q.size() > 0) ? q[0].pc    : 32'h0);
        check("m_pcplus4_d", PCPLUS4_D, (q.size() > 0) ? q[0].pcp4  : 32'h0);
        check("m_bubble",    {28'b0, BUBBLE_CNT}, m_cnt);
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy,
                         input logic fl, input logic clr);
        IN_VALID  = v;
        PC_F      = pc;
        INSTR_F   = mk_instr(pc);
        PCPLUS4_F = pc + 32'd4;
        OUT_READY = ordy;
        FLUSH     = fl;
        CNT_CLR   = clr;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #12;
        check("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
        check("rst_in_ready",  {31'b0, IN_READY},  32'd1);
        check("rst_instr",     INSTR_D, NOP);
        check("rst_bubble",    {28'b0, BUBBLE_CNT}, 32'd0);
        RST = 1'b1;

        // Idle: counter saturates, then clears and restarts.
        for (int i = 0; i < 20; i++) tick();
        check("cnt_sat", {28'b0, BUBBLE_CNT}, 32'd15);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        check("cnt_clr", {28'b0, BUBBLE_CNT}, 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("cnt_reinc", {28'b0, BUBBLE_CNT}, 32'd1);

        // Streaming, one per cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
            tick();
            check("stream_pc", PC_D, 32'(i * 4));
            check("stream_ready", {31'b0, IN_READY}, 32'd1);
        end
        check("stream_cnt", {28'b0, BUBBLE_CNT}, 32'd2);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();

        // Pop to empty.
        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        tick();
        check("pop_pc_held", PC_D, 32'h40);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check("pop_valid", {31'b0, OUT_VALID}, 32'd0);
        check("pop_instr", INSTR_D, NOP);
        check("pop_pc",    PC_D, 32'h0);

        // Backpressure.
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
        tick();
        check("bp_ready_low", {31'b0, IN_READY}, 32'd0);
        check("bp_pc_100", PC_D, 32'h100);
        drive(1'b1, 32'h108, 1'b0, 1'b0, 1'b0);
        tick();
        check("bp_still_full", {31'b0, IN_READY}, 32'd0);
        drive(1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
        tick();
        check("bp_pc_104", PC_D, 32'h104);
        tick();
        check("bp_pc_108", PC_D, 32'h108);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check("bp_drained", {31'b0, OUT_VALID}, 32'd0);

        // Flush in TWO with a live input that must be dropped.
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h208, 1'b0, 1'b1, 1'b0);
        tick();
        check("fl_valid", {31'b0, OUT_VALID}, 32'd0);
        check("fl_instr", INSTR_D, NOP);
        check("fl_ready", {31'b0, IN_READY}, 32'd1);
        drive(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
        tick();
        check("fl_next_pc", PC_D, 32'h300);
        check("fl_next_p4", PCPLUS4_D, 32'h304);

        // Flush and counter clear together.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        check("flclr_cnt",   {28'b0, BUBBLE_CNT}, 32'd0);
        check("flclr_valid", {31'b0, OUT_VALID}, 32'd0);

        // Asynchronous reset while full.
        drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
        tick();
        check("pre_rst_full", {31'b0, IN_READY}, 32'd0);
        RST = 1'b0;
        #1;
        check("arst_valid", {31'b0, OUT_VALID}, 32'd0);
        check("arst_ready", {31'b0, IN_READY}, 32'd1);
        check("arst_instr", INSTR_D, NOP);
        check("arst_pc",    PC_D, 32'h0);
        check("arst_cnt",   {28'b0, BUBBLE_CNT}, 32'd0);
        #1;
        RST = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
